// File: rtl/cpu6_bus_pkg.sv
// Shared types and constants for the CPU6 bus responder: FSM states,
// address-region decode and the fixed console/unmapped values.
package cpu6_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2,
    ST_HOLD = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RGN_RAM   = 2'd0,
    RGN_CDATA = 2'd1,
    RGN_CSTAT = 2'd2,
    RGN_NONE  = 2'd3
  } region_t;

  localparam logic [15:0] CONSOLE_DATA_DEF = 16'hF200;
  localparam logic [15:0] CONSOLE_STAT_DEF = 16'hF201;
  localparam logic [7:0]  UNMAPPED_READ    = 8'hFF;

  // RAM wins over the console registers if the RAM is made large enough
  // to overlap them, so a 64K RAM build still behaves as plain memory.
  function automatic region_t decode_addr(
    input logic [15:0] addr,
    input int          ram_aw,
    input logic [15:0] cdata,
    input logic [15:0] cstat
  );
    if ((addr >> ram_aw) == 16'd0) return RGN_RAM;
    else if (addr == cdata)        return RGN_CDATA;
    else if (addr == cstat)        return RGN_CSTAT;
    else                           return RGN_NONE;
  endfunction

endpackage

// File: rtl/cpu6_ram.sv
// Single-port 2^AW x 8 synchronous RAM with a registered read port.
// Read-before-write on a shared address; contents are never reset.
module cpu6_ram #(
  parameter int AW = 12
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdata,
  output logic [7:0]    o_rdata
);

  logic [7:0] r_mem [0:(1<<AW)-1];
  logic [7:0] r_rdata;

  // Store on write enable; always register the addressed byte.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
    r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/cpu6_memory_responder.sv
// CPU6 bus responder: latches a CPU read/write, waits a fixed number of
// cycles, services it from RAM or the console register and returns a
// one-cycle registered ready. HOLD keeps a held enable from re-triggering.
module cpu6_memory_responder
  import cpu6_bus_pkg::*;
#(
  parameter int          RAM_AW       = 12,
  parameter logic [15:0] CONSOLE_DATA = CONSOLE_DATA_DEF,
  parameter logic [15:0] CONSOLE_STAT = CONSOLE_STAT_DEF,
  parameter int          WAIT_STATES  = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] addressBus,
  input  logic [7:0]  writeData,
  input  logic        readEnable,
  input  logic        writeEnable,
  output logic [7:0]  readData,
  output logic        ready,
  output logic [7:0]  txData,
  output logic        txValid,
  input  logic        txReady
);

  localparam bit         HAS_WAIT  = (WAIT_STATES > 0);
  localparam logic [3:0] WAIT_LOAD = HAS_WAIT ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t              r_state;
  state_t              w_state_next;
  logic [15:0]         r_addr;
  logic                r_is_write;
  logic [7:0]          r_wdata;
  logic [3:0]          r_wcnt;
  logic                r_ready;
  logic [7:0]          r_read_data;
  logic [7:0]          r_tx_data;
  logic                r_tx_valid;

  region_t             w_region;
  logic                w_accept;
  logic                w_ack;
  logic                w_ram_we;
  logic                w_tx_load;
  logic                w_tx_free;
  logic [7:0]          w_read_value;
  logic [RAM_AW-1:0]   w_ram_addr;
  logic [7:0]          w_ram_rdata;

  assign w_region  = decode_addr(r_addr, RAM_AW, CONSOLE_DATA, CONSOLE_STAT);
  // The console buffer can take a new byte if empty or draining this edge.
  assign w_tx_free = !r_tx_valid || txReady;

  // While idle the RAM looks at the live bus so the stored byte is already
  // registered by the time a zero-wait access reaches DONE.
  assign w_ram_addr = (r_state == ST_IDLE) ? addressBus[RAM_AW-1:0]
                                           : r_addr[RAM_AW-1:0];

  cpu6_ram #(.AW(RAM_AW)) u_ram (
    .i_clk   (clock),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (r_wdata),
    .o_rdata (w_ram_rdata)
  );

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (readEnable || writeEnable)
                 w_state_next = HAS_WAIT ? ST_WAIT : ST_DONE;
      ST_WAIT: if (r_wcnt == 4'd0) w_state_next = ST_DONE;
      ST_DONE: if (w_ack) w_state_next = ST_HOLD;
      ST_HOLD: if (!readEnable && !writeEnable) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Per-state strobes; a console data write stalls DONE until the buffer frees.
  always_comb begin
    w_accept  = 1'b0;
    w_ack     = 1'b0;
    w_ram_we  = 1'b0;
    w_tx_load = 1'b0;
    case (r_state)
      ST_IDLE: w_accept = readEnable || writeEnable;
      ST_DONE: begin
        w_ack     = !(r_is_write && (w_region == RGN_CDATA) && !w_tx_free);
        w_ram_we  = w_ack && r_is_write && (w_region == RGN_RAM);
        w_tx_load = w_ack && r_is_write && (w_region == RGN_CDATA);
      end
      default: ;
    endcase
  end

  // Read result selected by the latched address region.
  always_comb begin
    w_read_value = UNMAPPED_READ;
    case (w_region)
      RGN_RAM:   w_read_value = w_ram_rdata;
      RGN_CDATA: w_read_value = r_tx_data;
      RGN_CSTAT: w_read_value = {7'd0, !r_tx_valid};
      default:   w_read_value = UNMAPPED_READ;
    endcase
  end

  // Request latch and wait-state counter; writeEnable wins when both are set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addr     <= 16'd0;
      r_is_write <= 1'b0;
      r_wdata    <= 8'd0;
      r_wcnt     <= 4'd0;
    end else if (w_accept) begin
      r_addr     <= addressBus;
      r_is_write <= writeEnable;
      r_wdata    <= writeData;
      r_wcnt     <= WAIT_LOAD;
    end else if (r_state == ST_WAIT && r_wcnt != 4'd0) begin
      r_wcnt <= r_wcnt - 4'd1;
    end
  end

  // Registered acknowledge and read data; readData holds until the next read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ready     <= 1'b0;
      r_read_data <= 8'd0;
    end else begin
      r_ready <= w_ack;
      if (w_ack && !r_is_write) r_read_data <= w_read_value;
    end
  end

  // Console output buffer: a load has priority over the drain in the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tx_data  <= 8'd0;
      r_tx_valid <= 1'b0;
    end else if (w_tx_load) begin
      r_tx_data  <= r_wdata;
      r_tx_valid <= 1'b1;
    end else if (r_tx_valid && txReady) begin
      r_tx_valid <= 1'b0;
    end
  end

  assign ready    = r_ready;
  assign readData = r_read_data;
  assign txData   = r_tx_data;
  assign txValid  = r_tx_valid;

endmodule

// File: tb/tb_cpu6_memory_responder.sv
// Scoreboard bench: instance d has WAIT_STATES=d. Stimulus pushes expected
// responses; a monitor pops on every ready and on every console handshake.
module tb_cpu6_memory_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst    [2];
  logic [15:0] a_bus  [2];
  logic [7:0]  w_data [2];
  logic        re     [2];
  logic        we     [2];
  logic        tx_rdy [2];
  logic [7:0]  r_data [2];
  logic        rdy    [2];
  logic [7:0]  tx_data[2];
  logic        tx_vld [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    cpu6_memory_responder #(
      .RAM_AW(12), .CONSOLE_DATA(16'hF200), .CONSOLE_STAT(16'hF201),
      .WAIT_STATES(gi)
    ) u_dut (
      .clock(clk), .reset(rst[gi]), .addressBus(a_bus[gi]),
      .writeData(w_data[gi]), .readEnable(re[gi]), .writeEnable(we[gi]),
      .readData(r_data[gi]), .ready(rdy[gi]), .txData(tx_data[gi]),
      .txValid(tx_vld[gi]), .txReady(tx_rdy[gi])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit         is_rd;
    logic [7:0] data;
    int         due;
    int         id;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [7:0] txq[$];

  // Reference model: plain byte arrays plus console counters.
  logic [7:0] mem_m [2][4096];
  logic [7:0] last_tx   = 8'h00;
  int         tx_pushed = 0;
  int         tx_popped = 0;
  int         txn_id    = 0;
  logic [15:0] pool [8];

  task automatic chk(input string name, input int id, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (txn %0d): got %02h, expected %02h", name, id, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic sb_pop(input int d);
    exp_t e;
    n_checks++;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      n_fail++;
      $display("FAIL unexpected_ready d%0d: got ready=1 at cycle %0d, expected none", d, cyc);
      return;
    end
    e = (d == 0) ? q0.pop_front() : q1.pop_front();
    if (e.is_rd) chk("read_data", e.id, r_data[d], e.data);
    if (e.due >= 0) chk_int($sformatf("ready_cycle txn %0d", e.id), cyc, e.due);
  endtask

  // Monitor: scoreboard pop on ready, console sink check on handshake.
  always @(negedge clk) begin
    #1;
    for (int d = 0; d < 2; d++) if (rdy[d] === 1'b1) sb_pop(d);
    if (tx_vld[1] === 1'b1 && tx_rdy[1] === 1'b1) begin
      n_checks++;
      if (txq.size() == 0) begin
        n_fail++;
        $display("FAIL tx_sink: got byte %02h, expected no byte", tx_data[1]);
      end else begin
        logic [7:0] b;
        b = txq.pop_front();
        tx_popped++;
        if (tx_data[1] !== b) begin
          n_fail++;
          $display("FAIL tx_sink: got %02h, expected %02h", tx_data[1], b);
        end
      end
    end
  end

  // One bus access: drive, push expectation, wait for ready, optionally hold.
  task automatic access(input int d, input bit wr, input bit rd, input logic [15:0] a,
                        input logic [7:0] wd, input int hold, input bit chk_lat);
    exp_t e;
    bit   got;
    @(negedge clk);
    a_bus[d] = a; w_data[d] = wd; we[d] = wr; re[d] = rd;
    e.is_rd = !wr;
    e.data  = 8'hFF;
    e.id    = txn_id++;
    e.due   = chk_lat ? cyc + d + 2 : -1;
    if (wr) begin
      if (a < 16'h1000) mem_m[d][a[11:0]] = wd;
      else if (a == 16'hF200) begin
        txq.push_back(wd); last_tx = wd; tx_pushed++;
      end
    end else begin
      if (a < 16'h1000)       e.data = mem_m[d][a[11:0]];
      else if (a == 16'hF200) e.data = last_tx;
      else if (a == 16'hF201) e.data = {7'd0, tx_pushed == tx_popped};
    end
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    $display("txn %0d d%0d %s addr=%04h wdata=%02h exp_rdata=%02h", e.id, d,
             wr ? "WR" : "RD", a, wd, e.data);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = (rdy[d] === 1'b1);
    end
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL ready_timeout (txn %0d): got no ready in 100 cycles, expected one", e.id);
      if (d == 0) q0.delete(); else q1.delete();
    end
    repeat (hold) @(negedge clk);
    we[d] = 1'b0; re[d] = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    pool = '{16'h0000, 16'h0001, 16'h0123, 16'h07FF, 16'h0800, 16'h0FFE, 16'h0FFF, 16'h0010};
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; a_bus[d] = 16'h0; w_data[d] = 8'h0;
      re[d] = 1'b0; we[d] = 1'b0; tx_rdy[d] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_ready", d, {7'd0, rdy[d]}, 8'h00);
      chk("reset_readData", d, r_data[d], 8'h00);
      chk("reset_txData", d, tx_data[d], 8'h00);
      chk("reset_txValid", d, {7'd0, tx_vld[d]}, 8'h00);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;
    repeat (2) @(negedge clk);

    // Status after reset, basic RAM write/read on both wait-state settings.
    access(1, 0, 1, 16'hF201, 8'h00, 0, 1);
    for (int d = 0; d < 2; d++) begin
      access(d, 1, 0, 16'h0123, 8'h5A, 0, 1);
      access(d, 0, 1, 16'h0123, 8'h00, 0, 1);
    end

    // Enable held past ready: one pulse only, next access still timed normally.
    access(1, 0, 1, 16'h0123, 8'h00, 5, 1);
    access(1, 1, 0, 16'h0124, 8'h77, 5, 1);
    access(1, 0, 1, 16'h0124, 8'h00, 0, 1);

    // Console stall: second byte waits until the sink drains the first.
    tx_rdy[1] = 1'b0;
    access(1, 1, 0, 16'hF200, 8'h41, 0, 1);
    fork
      access(1, 1, 0, 16'hF200, 8'h42, 0, 0);
      begin
        for (int i = 0; i < 6; i++) begin
          @(negedge clk);
          chk("stall_ready_low", i, {7'd0, rdy[1]}, 8'h00);
        end
        tx_rdy[1] = 1'b1;
        @(negedge clk);
        tx_rdy[1] = 1'b0;
      end
    join
    access(1, 0, 1, 16'hF201, 8'h00, 0, 1);
    access(1, 0, 1, 16'hF200, 8'h00, 0, 1);
    tx_rdy[1] = 1'b1;
    access(1, 0, 1, 16'hF201, 8'h00, 0, 1);

    // Unmapped accesses and both-enables-as-write.
    access(1, 1, 0, 16'h0000, 8'h11, 0, 1);
    access(1, 0, 1, 16'h8000, 8'h00, 0, 1);
    access(1, 1, 0, 16'h8000, 8'hEE, 0, 1);
    access(1, 0, 1, 16'h0000, 8'h00, 0, 1);
    access(1, 1, 1, 16'h0010, 8'h99, 0, 1);
    access(1, 0, 1, 16'h0010, 8'h00, 0, 1);
    access(1, 1, 0, 16'hF201, 8'h3C, 0, 1);
    access(1, 0, 1, 16'hF202, 8'h00, 0, 1);

    // Reset during WAIT of a RAM write: no ack, no RAM change, outputs cleared.
    @(negedge clk);
    a_bus[1] = 16'h0123; w_data[1] = 8'hC3; we[1] = 1'b1;
    @(negedge clk);
    rst[1] = 1'b1;
    #1;
    chk("midreset_ready", 0, {7'd0, rdy[1]}, 8'h00);
    chk("midreset_readData", 0, r_data[1], 8'h00);
    chk("midreset_txData", 0, tx_data[1], 8'h00);
    chk("midreset_txValid", 0, {7'd0, tx_vld[1]}, 8'h00);
    we[1] = 1'b0;
    last_tx = 8'h00;
    repeat (2) @(negedge clk);
    rst[1] = 1'b0;
    repeat (3) @(negedge clk);
    access(1, 0, 1, 16'h0123, 8'h00, 0, 1);
    access(1, 0, 1, 16'hF200, 8'h00, 0, 1);

    // Randomized traffic over a known address pool.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 8; i++) access(d, 1, 0, pool[i], 8'($urandom), 0, 1);
    for (int i = 0; i < 80; i++) begin
      int         sel;
      int         hold;
      logic [15:0] a;
      logic [7:0]  wd;
      sel  = $urandom_range(0, 9);
      hold = $urandom_range(0, 2);
      a    = pool[$urandom_range(0, 7)];
      wd   = 8'($urandom);
      case (sel)
        0, 1, 2: access(1, 1, 0, a, wd, hold, 1);
        3, 4:    access(1, 0, 1, a, wd, hold, 1);
        5:       access(1, 1, 0, 16'hF200, wd, hold, 1);
        6:       access(1, 0, 1, ($urandom_range(0, 1) == 0) ? 16'hF200 : 16'hF201, wd, hold, 1);
        7:       access(1, $urandom_range(0, 1) == 1, 1'b1, 16'h9000 + 16'($urandom_range(0, 255)), wd, hold, 1);
        8:       access(1, 1, 1, a, wd, hold, 1);
        default: access(0, $urandom_range(0, 1) == 1, 1'b1, a, wd, hold, 1);
      endcase
    end

    repeat (5) @(negedge clk);
    chk_int("scoreboard_q0_empty", q0.size(), 0);
    chk_int("scoreboard_q1_empty", q1.size(), 0);
    chk_int("tx_queue_empty", txq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu6_memory_responder.md
# cpu6_memory_responder

Bus responder on the far side of the CPU6 address/data bus: it decodes each CPU-initiated read or write, services it from an on-chip RAM or a console output register, and acknowledges with a registered `ready` after a programmable number of wait states. It sits beside `CPU6` in the system top and test benches, sharing the `Clock` generator's clock and reset, and replaces ad-hoc bench memories.

## Interface
Parameters:
- `RAM_AW`, 12: RAM address width; RAM occupies 0x0000 to 2^RAM_AW-1.
- `CONSOLE_DATA`, 16'hF200: console data register address.
- `CONSOLE_STAT`, 16'hF201: console status register address.
- `WAIT_STATES`, 1: cycles inserted between request sample and `ready` (0–15).

Ports:
- `clock` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `addressBus` in 16: CPU address, valid while an enable is high.
- `writeData` in 8: CPU write data, valid with `writeEnable`.
- `readEnable` in 1: CPU read request, held until `ready`.
- `writeEnable` in 1: CPU write request, held until `ready`.
- `readData` out 8: read result, valid in the `ready` cycle.
- `ready` out 1: one-cycle access acknowledge.
- `txData` out 8: console byte.
- `txValid` out 1: console byte pending.
- `txReady` in 1: console sink accepts byte when `txValid && txReady`.

## Operation
- FSM states: IDLE, WAIT, DONE, HOLD.
- IDLE: if `writeEnable` or `readEnable` is high, latch address, direction and `writeData`; go to WAIT (`WAIT_STATES`>0) or DONE. Both enables high = write (read ignored).
- WAIT: 4-bit counter loads `WAIT_STATES-1`, decrements; at zero go to DONE.
- DONE: perform access; `ready`=1 for exactly one cycle; then HOLD.
- HOLD: stay until both enables are low, then IDLE. Prevents a held enable from being serviced twice.
- Decode: address < 2^RAM_AW → RAM; `CONSOLE_DATA`/`CONSOLE_STAT` → console; otherwise unmapped.
- RAM read returns stored byte; RAM write stores `writeData`.
- Console data write: if `txValid`=0 (or `txValid && txReady` in the same cycle), load `txData`, set `txValid`; otherwise stay in DONE with `ready` low until the buffer frees. Console data read returns `txData`.
- Status read: bit0 = !`txValid`, bits 7:1 = 0. Writes to status are ignored and acknowledged.
- Unmapped read returns 8'hFF; unmapped write discarded; both acknowledged normally.
- `txValid` clears on `txValid && txReady` when no load happens in the same cycle.

## Timing
- Reset values: state IDLE, `ready`=0, `readData`=8'h00, `txData`=8'h00, `txValid`=0, wait counter 0. RAM contents are not cleared.
- `ready` and `readData` are registered. With the request sampled at edge k, `ready` is high for the cycle after edge k+WAIT_STATES+1, assuming no console stall.
- `readData` holds its value after `ready` until the next read completes.
- Console stall: `ready` is delayed until the edge at which `txValid` is low or is being consumed; the data is loaded at that same edge.
- Reset asserted mid-access: the access is abandoned with no RAM or console side effects after reset, and all outputs go to reset values immediately.
- Enables must not change between sample and `ready`; changes are ignored, since the latched copy is used.

## Structure
- Package `cpu6_bus_pkg`: FSM state enum, `CONSOLE_DATA`/`CONSOLE_STAT` defaults, unmapped read value 8'hFF.
- Sub-module `cpu6_ram`: synchronous single-port RAM, `2^RAM_AW`×8, one write port and one registered read port, no reset. The responder owns decode, FSM and console register.

## Test plan
- Reset then idle: outputs 0, `txValid`=0; status read returns 8'h01.
- RAM write 8'h5A to 0x0123, then read 0x0123 with `WAIT_STATES`=1 → `ready` 2 cycles after sample, `readData`=8'h5A; `WAIT_STATES`=0 → 1 cycle.
- Enable held 5 cycles past `ready` → exactly one `ready` pulse; the next access is accepted only after the enables drop.
- Console write 8'h41 with `txReady`=0, then a second write 8'h42 → second `ready` withheld; raise `txReady` → 8'h41 consumed, 8'h42 loaded the same edge, `ready` pulses, status reads 8'h00.
- Read 0x8000 → 8'hFF; write 0x8000 → acked with no RAM change (0x0000 unaffected); both enables high to 0x0010 → treated as write.
- Reset asserted during WAIT of a RAM write → `ready` never pulses, and the location keeps its old value on a later read.
